// File: rtl/maquina_jornal_param.sv
// Newspaper vending controller with credit in quarter units (25 centavos).
// A session starts on inicio; coins add credit, product requests deduct
// their price and release one paper, and refund (requested or after an idle
// timeout) pays the credit back one coin per cycle, largest coin first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no session, credit held at zero, waiting for inicio
// ACEITA  | accepting coins and requests, idle timer running
// ENTREGA | one-cycle release of the latched product
// DEVOLVE | paying back credit, one coin per cycle, then back to IDLE
module maquina_jornal_param #(
    parameter int CW          = 5,
    parameter int VALOR_U     = 4,
    parameter int PRECO_JL    = 2,
    parameter int PRECO_JN    = 4,
    parameter int CREDITO_MAX = 16,
    parameter int TIMEOUT     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inicio,
    input  logic          c,
    input  logic          u,
    input  logic          jl,
    input  logic          jn,
    input  logic          dt,
    output logic          ljl,
    output logic          ljn,
    output logic          td,
    output logic          dev_u,
    output logic          dev_c,
    output logic          rej,
    output logic [CW-1:0] credito,
    output logic [2:0]    ea
);

    // Counter wide enough to hold TIMEOUT itself.
    localparam int TW = $clog2(TIMEOUT + 1);

    // Credit arithmetic is done one bit wider so a coin on top of a nearly
    // full register cannot wrap before the overflow compare.
    localparam logic [CW:0]   UM_W       = (CW+1)'(1);
    localparam logic [CW:0]   VALOR_W    = (CW+1)'(VALOR_U);
    localparam logic [CW:0]   PRECO_JL_W = (CW+1)'(PRECO_JL);
    localparam logic [CW:0]   PRECO_JN_W = (CW+1)'(PRECO_JN);
    localparam logic [CW:0]   MAX_W      = (CW+1)'(CREDITO_MAX);
    localparam logic [CW-1:0] UM_C       = CW'(1);
    localparam logic [TW-1:0] TMO_W      = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_UM     = TW'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACEITA  = 3'd1,
        ST_ENTREGA = 3'd2,
        ST_DEVOLVE = 3'd3
    } estado_t;

    estado_t       ea_q, ea_d;
    logic [CW-1:0] credito_q, credito_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rej_q, rej_d;
    logic          prod_jn_q, prod_jn_d;

    logic [CW:0]   cred_x;
    logic [CW:0]   soma_c;
    logic [CW:0]   soma_u;
    logic [TW-1:0] tmo_inc;
    logic          evento;

    assign cred_x  = {1'b0, credito_q};
    assign soma_c  = cred_x + UM_W;
    assign soma_u  = cred_x + VALOR_W;
    assign tmo_inc = tmo_q + TMO_UM;
    assign evento  = dt | jn | jl | c | u;

    // State, credit, idle timer, reject pulse and latched product registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ea_q      <= ST_IDLE;
            credito_q <= '0;
            tmo_q     <= '0;
            rej_q     <= 1'b0;
            prod_jn_q <= 1'b0;
        end else begin
            ea_q      <= ea_d;
            credito_q <= credito_d;
            tmo_q     <= tmo_d;
            rej_q     <= rej_d;
            prod_jn_q <= prod_jn_d;
        end
    end

    // Next-state logic: one accepted event per ACEITA cycle, in priority order.
    always_comb begin
        ea_d      = ea_q;
        credito_d = credito_q;
        tmo_d     = tmo_q;
        rej_d     = 1'b0;
        prod_jn_d = prod_jn_q;

        case (ea_q)
            ST_IDLE: begin
                credito_d = '0;
                tmo_d     = '0;
                if (inicio) begin
                    ea_d = ST_ACEITA;
                end
            end

            ST_ACEITA: begin
                // Any request, even an unaffordable one, counts as activity.
                tmo_d = evento ? '0 : tmo_inc;

                if (dt) begin
                    ea_d = ST_DEVOLVE;
                end else if (jn) begin
                    if (cred_x >= PRECO_JN_W) begin
                        credito_d = CW'(cred_x - PRECO_JN_W);
                        prod_jn_d = 1'b1;
                        ea_d      = ST_ENTREGA;
                    end
                end else if (jl) begin
                    if (cred_x >= PRECO_JL_W) begin
                        credito_d = CW'(cred_x - PRECO_JL_W);
                        prod_jn_d = 1'b0;
                        ea_d      = ST_ENTREGA;
                    end
                end else if (c) begin
                    if (soma_c <= MAX_W) begin
                        credito_d = soma_c[CW-1:0];
                    end else begin
                        rej_d = 1'b1;
                    end
                end else if (u) begin
                    if (soma_u <= MAX_W) begin
                        credito_d = soma_u[CW-1:0];
                    end else begin
                        rej_d = 1'b1;
                    end
                end else if (tmo_inc == TMO_W) begin
                    ea_d = ST_DEVOLVE;
                end
            end

            ST_ENTREGA: begin
                tmo_d = '0;
                ea_d  = ST_ACEITA;
            end

            ST_DEVOLVE: begin
                tmo_d = '0;
                if (cred_x >= VALOR_W) begin
                    credito_d = CW'(cred_x - VALOR_W);
                end else if (credito_q != '0) begin
                    credito_d = credito_q - UM_C;
                end else begin
                    ea_d = ST_IDLE;
                end
            end

            default: begin
                ea_d      = ST_IDLE;
                credito_d = '0;
                tmo_d     = '0;
                prod_jn_d = 1'b0;
            end
        endcase
    end

    // Release and change outputs decoded only from registered state and credit.
    always_comb begin
        ljl   = 1'b0;
        ljn   = 1'b0;
        td    = 1'b0;
        dev_u = 1'b0;
        dev_c = 1'b0;

        case (ea_q)
            ST_ENTREGA: begin
                ljl = ~prod_jn_q;
                ljn = prod_jn_q;
            end
            ST_DEVOLVE: begin
                td = 1'b1;
                if (cred_x >= VALOR_W) begin
                    dev_u = 1'b1;
                end else if (credito_q != '0) begin
                    dev_c = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign rej     = rej_q;
    assign credito = credito_q;
    assign ea      = ea_q;

endmodule

// File: tb/tb_maquina_jornal_param.sv
// Bench for maquina_jornal_param: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a behavioural model of the vending rules.
module tb_maquina_jornal_param;

    localparam int CW          = 5;
    localparam int VALOR_U     = 4;
    localparam int PRECO_JL    = 2;
    localparam int PRECO_JN    = 4;
    localparam int CREDITO_MAX = 16;
    localparam int TIMEOUT     = 8;

    localparam int M_IDLE = 0, M_ACEITA = 1, M_ENTREGA = 2, M_DEVOLVE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          inicio, c, u, jl, jn, dt;
    logic          ljl, ljn, td, dev_u, dev_c, rej;
    logic [CW-1:0] credito;
    logic [2:0]    ea;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model state.
    int m_st;
    int m_cred;
    int m_idle;
    bit m_rej;
    bit m_jn;

    maquina_jornal_param #(
        .CW(CW), .VALOR_U(VALOR_U), .PRECO_JL(PRECO_JL), .PRECO_JN(PRECO_JN),
        .CREDITO_MAX(CREDITO_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .c(c), .u(u), .jl(jl), .jn(jn), .dt(dt),
        .ljl(ljl), .ljn(ljn), .td(td), .dev_u(dev_u), .dev_c(dev_c), .rej(rej),
        .credito(credito), .ea(ea)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_cred = 0; m_idle = 0; m_rej = 1'b0; m_jn = 1'b0;
    endtask

    // One clock of the vending rules, written directly from the behaviour.
    task automatic model_step(input bit i_, c_, u_, jl_, jn_, dt_);
        int st;
        st = m_st;
        m_rej = 1'b0;
        if (st == M_IDLE) begin
            m_cred = 0;
            m_idle = 0;
            if (i_) m_st = M_ACEITA;
        end else if (st == M_ACEITA) begin
            if (dt_ || jn_ || jl_ || c_ || u_) m_idle = 0;
            else m_idle = m_idle + 1;
            if (dt_) m_st = M_DEVOLVE;
            else if (jn_) begin
                if (m_cred >= PRECO_JN) begin
                    m_cred = m_cred - PRECO_JN; m_jn = 1'b1; m_st = M_ENTREGA;
                end
            end else if (jl_) begin
                if (m_cred >= PRECO_JL) begin
                    m_cred = m_cred - PRECO_JL; m_jn = 1'b0; m_st = M_ENTREGA;
                end
            end else if (c_) begin
                if (m_cred + 1 <= CREDITO_MAX) m_cred = m_cred + 1;
                else m_rej = 1'b1;
            end else if (u_) begin
                if (m_cred + VALOR_U <= CREDITO_MAX) m_cred = m_cred + VALOR_U;
                else m_rej = 1'b1;
            end else if (m_idle >= TIMEOUT) m_st = M_DEVOLVE;
        end else if (st == M_ENTREGA) begin
            m_idle = 0;
            m_st = M_ACEITA;
        end else begin
            m_idle = 0;
            if (m_cred >= VALOR_U) m_cred = m_cred - VALOR_U;
            else if (m_cred >= 1) m_cred = m_cred - 1;
            else m_st = M_IDLE;
        end
    endtask

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ea", ea, m_st);
            chk("credito", credito, m_cred);
            chk("ljl", ljl, (m_st == M_ENTREGA && !m_jn));
            chk("ljn", ljn, (m_st == M_ENTREGA && m_jn));
            chk("td", td, (m_st == M_DEVOLVE));
            chk("dev_u", dev_u, (m_st == M_DEVOLVE && m_cred >= VALOR_U));
            chk("dev_c", dev_c, (m_st == M_DEVOLVE && m_cred < VALOR_U && m_cred >= 1));
            chk("rej", rej, m_rej);
        end
    end

    task automatic cyc(input bit i_, c_, u_, jl_, jn_, dt_);
        inicio = i_; c = c_; u = u_; jl = jl_; jn = jn_; dt = dt_;
        @(posedge clk);
        if (rst) model_step(i_, c_, u_, jl_, jn_, dt_);
        else model_reset();
        #1;
    endtask

    task automatic idle1();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (ea !== 3'd0 && k < 40) begin
            idle1();
            k++;
        end
        chk("drain_to_idle", ea, 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ea"}, ea, 0);
        chk({nm, "_credito"}, credito, 0);
        chk({nm, "_outs"}, {ljl, ljn, td, dev_u, dev_c, rej}, 0);
    endtask

    // Asynchronous reset applied mid-cycle, released after the next edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk_zero("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic bit r(input int k);
        return ($urandom_range(0, k - 1) == 0);
    endfunction

    initial begin
        int pulses;
        int burst;
        rst = 1'b0;
        inicio = 0; c = 0; u = 0; jl = 0; jn = 0; dt = 0;
        model_reset();
        #3;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;

        // inicio, c, c, jl -> ENTREGA with local paper, no credit left
        cyc(1, 0, 0, 0, 0, 0);
        chk("s1_aceita", ea, 1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("s1_cred2", credito, 2);
        cyc(0, 0, 0, 1, 0, 0);
        chk("s1_entrega", ea, 2);
        chk("s1_ljl", ljl, 1);
        chk("s1_cred0", credito, 0);
        idle1();
        chk("s1_back", ea, 1);
        chk("s1_ljl_off", ljl, 0);
        cyc(0, 0, 0, 0, 0, 1);
        drain();

        // inicio, u, u, dt -> two 1-real coins, one empty cycle, IDLE
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("s2_cred8", credito, 8);
        cyc(0, 0, 0, 0, 0, 1);
        chk("s2_dev", ea, 3);
        chk("s2_devu1", {td, dev_u, dev_c}, 3'b110);
        idle1();
        chk("s2_cred4", credito, 4);
        chk("s2_devu2", {td, dev_u, dev_c}, 3'b110);
        idle1();
        chk("s2_cred0", credito, 0);
        chk("s2_empty", {td, dev_u, dev_c}, 3'b100);
        idle1();
        chk("s2_idle", ea, 0);
        chk("s2_td_off", td, 0);

        // credit 14, u rejected; c, c -> 16; c rejected; jn buys national
        cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0, 0);
        chk("s3_cred14", credito, 14);
        cyc(0, 0, 1, 0, 0, 0);
        chk("s3_rej_u", rej, 1);
        chk("s3_cred_kept", credito, 14);
        cyc(0, 1, 0, 0, 0, 0);
        chk("s3_rej_clear", rej, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("s3_cred16", credito, 16);
        cyc(0, 1, 0, 0, 0, 0);
        chk("s3_rej_c", rej, 1);
        chk("s3_cred16b", credito, 16);
        cyc(0, 0, 0, 0, 1, 0);
        chk("s3_ljn", ljn, 1);
        chk("s3_cred12", credito, 12);
        cyc(0, 0, 0, 0, 0, 1);
        drain();

        // inicio, c, then idle until timeout refund
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        repeat (7) idle1();
        chk("s4_still_aceita", ea, 1);
        idle1();
        chk("s4_timeout", ea, 3);
        chk("s4_devc", {td, dev_u, dev_c}, 3'b101);
        idle1();
        chk("s4_empty", {td, dev_u, dev_c}, 3'b100);
        idle1();
        chk("s4_idle", ea, 0);

        // credit 3: jn ignored; dt+jn+c -> three 25-centavo coins
        cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("s5_jn_ignored", ea, 1);
        chk("s5_cred3", credito, 3);
        cyc(0, 1, 0, 0, 1, 1);
        chk("s5_dev", ea, 3);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (dev_c === 1'b1) pulses++;
            if (k < 3) idle1();
        end
        chk("s5_pulses", pulses, 3);
        idle1();
        chk("s5_idle", ea, 0);

        // reset in the middle of a refund with credit 5
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("s6_devu", dev_u, 1);
        chk("s6_cred5", credito, 5);
        do_reset();
        repeat (3) idle1();
        chk_zero("s6_after");

        // randomized traffic with idle bursts and occasional resets
        burst = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if (burst > 0) begin
                burst--;
                idle1();
            end else begin
                if ($urandom_range(0, 39) == 0) burst = $urandom_range(4, 12);
                cyc(r(2), r(3), r(4), r(6), r(6), r(20));
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
